// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for the combinational ALU: holds operands/opcode for a
// per-op latency, captures the result and returns it over a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a request; ALU ports keep the last issued op
// EXEC  | ALU ports held, latency counter running down to zero
// RESP  | result presented, waiting for rsp_ready
module alu_op_sequencer #(
    parameter int XLEN       = 64,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic [XLEN-1:0] alu_input1,
    output logic [XLEN-1:0] alu_input2,
    output logic [1:0]      signal,
    input  logic [XLEN-1:0] alu_output,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_div0
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Counter holds L-1 so the capture edge is the L-th edge after accept.
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            alu_input1 <= '0;
            alu_input2 <= '0;
            signal     <= '0;
            rsp_result <= '0;
            rsp_div0   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_input1 <= req_a;
                        alu_input2 <= req_b;
                        signal     <= req_op;
                        case (req_op)
                            OP_MUL:  count <= MUL_LOAD;
                            OP_DIV:  count <= DIV_LOAD;
                            default: count <= '0;
                        endcase
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        // Divide by zero returns all ones regardless of the ALU.
                        if (signal == OP_DIV && alu_input2 == '0) begin
                            rsp_result <= '1;
                            rsp_div0   <= 1'b1;
                        end else begin
                            rsp_result <= alu_output;
                            rsp_div0   <= 1'b0;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
